matrix_scan_bcm: RTL and testbench
==================================

Name: matrix_scan_bcm

Overview:
Parametrised successor to the LED-matrix scan generator. It drives the row/column/latch/OE timing for an N-column, 2^ROW_BITS-row-pair HUB75 panel, using binary-coded modulation (BCM) with configurable bit depth. It also adds a global dimming control that scales each bitplane's OE window, plus an enable/idle mode. It sits between the top-level clock/reset and the framebuffer fetch and pixel_split path.

Parameters:
COLUMNS, 64, pixels shifted per row; must be at least 2.
ROW_BITS, 4, row address width; there are 2^ROW_BITS scanned rows.
BCM_BITS, 6, bitplanes per row; this is the width of brightness_mask.
PIXEL_DIV, 1, clk_in cycles per clk_pixel half-period; must be at least 1.
BASE_TICKS, 16, OE window length for bitplane 0 in clk_in cycles; plane b uses BASE_TICKS<<b.
DIM_WIDTH, 8, width of dim_level.

Ports:
clk_in  input  1  system clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  scan enable; sampled at each plane start.
dim_level  input  DIM_WIDTH  global brightness; sampled in LATCH.
column_address  output  $clog2(COLUMNS)  column currently being fetched and shifted.
row_address  output  ROW_BITS  row being shifted, used by the fetch path.
row_address_active  output  ROW_BITS  row driven to the panel A-D lines.
clk_pixel_load  output  1  one-cycle pulse at the start of each pixel; this is the fetch request.
clk_pixel  output  1  panel shift clock.
row_latch  output  1  panel latch strobe.
output_enable  output  1  active-high display enable; the top level inverts it for the panel pin.
brightness_mask  output  BCM_BITS  one-hot current bitplane.
frame_start  output  1  one-cycle pulse when the scan wraps to row 0, plane 0.

Behaviour:
- Reset values: all counters and addresses 0; clk_pixel, clk_pixel_load, row_latch, output_enable and frame_start all 0; brightness_mask = 1.
- Reset applies on the next clk_in edge from any state, including mid-SHIFT and mid-SHOW. The state machine returns to IDLE.
- States: IDLE, SHIFT, BLANK, LATCH, SHOW.
- IDLE:
  - output_enable = 0.
  - Go to SHIFT on the first cycle that enable = 1.
- SHIFT:
  - Each pixel takes 2*PIXEL_DIV cycles.
  - clk_pixel_load pulses on the first cycle of each pixel.
  - clk_pixel is 0 for the first PIXEL_DIV cycles of the pixel and 1 for the last PIXEL_DIV cycles.
  - column_address increments after each pixel.
  - After column COLUMNS-1 completes: column_address wraps to 0 and the state goes to BLANK.
  - output_enable = 0 throughout SHIFT.
- BLANK: lasts 2 cycles with output_enable = 0 and clk_pixel = 0.
- LATCH:
  - Lasts 2 cycles with row_latch = 1.
  - row_address_active <= row_address on the first LATCH cycle. The active row therefore never changes while OE is high.
  - dim_level is captured into dim_q.
- SHOW:
  - Window length T = BASE_TICKS << b, where b is the index of the set bit in brightness_mask.
  - on_ticks = (T * dim_q) >> DIM_WIDTH, computed at full width: $clog2(BASE_TICKS)+BCM_BITS+DIM_WIDTH bits.
  - output_enable = 1 for the first on_ticks cycles of the window and 0 for the rest. If dim_q = 0, OE is never asserted.
  - SHOW always lasts exactly T cycles regardless of dimming, so the frame rate is independent of dim_level.
- End of SHOW:
  - Rotate brightness_mask left by one.
  - If the plane just shown was the MSB: mask returns to 1 and row_address increments.
  - If row_address was 2^ROW_BITS-1: it wraps to 0 and frame_start pulses on the same cycle the mask returns to 1.
  - Then go to SHIFT if enable = 1, otherwise IDLE.
- enable deasserted mid-plane: the current plane completes (SHIFT, BLANK, LATCH, SHOW), then the block enters IDLE with addresses held.
- Outputs are registered; none is driven combinationally from an input.

Decomposition:
- Package matrix_scan_pkg contains:
  - state enum: IDLE, SHIFT, BLANK, LATCH, SHOW;
  - constants BLANK_CYCLES = 2 and LATCH_CYCLES = 2;
  - a width helper function for the on_ticks computation.
- One sub-module, oe_window_timer:
  - inputs: start, plane index, dim_q;
  - outputs: output_enable and done.
  - It owns the T and on_ticks arithmetic and the window counter.

Test Plan (COLUMNS=4, ROW_BITS=1, BCM_BITS=2, PIXEL_DIV=1, BASE_TICKS=16, DIM_WIDTH=8):
1. Release reset with enable = 1, dim_level = 255. Required: clk_pixel_load pulses on SHIFT cycles 0,2,4,6; clk_pixel is high on cycles 1,3,5,7; column_address steps 0,1,2,3 then returns to 0; OE stays 0.
2. Check the SHIFT-to-LATCH sequence. Required: exactly 2 BLANK cycles with OE = 0, then row_latch = 1 for exactly 2 cycles; row_address_active takes row_address on the first LATCH cycle and never changes while OE = 1.
3. dim_level = 255. Required: plane 0 OE high for 15 of 16 cycles, plane 1 OE high for 31 of 32. Repeat with dim_level = 128: 8/16 and 16/32. Repeat with dim_level = 0: OE never high, and SHOW still lasts 16 then 32 cycles.
4. Run a full frame (2 rows × 2 planes). Required: mask sequence 01,10,01,10; row_address sequence 0,0,1,1 then 0; frame_start pulses exactly once at the wrap.
5. Assert reset on cycle 5 of a plane-1 SHOW. Required: on the next edge OE = 0, mask = 01, row_address = 0, state = IDLE; with enable = 1, SHIFT restarts on the following cycle.
6. Drop enable at SHIFT column 1. Required: the plane finishes through SHOW and the block then idles with OE = 0. Change dim_level mid-SHOW: no effect until the next LATCH.

Source files
------------

// File: rtl/matrix_scan_bcm_pkg.sv
// Shared types and constants for the BCM matrix scan generator.
// Width helpers keep the OE window arithmetic consistent between top and timer.
package matrix_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        SHOW
    } scan_state_t;

    localparam int BLANK_CYCLES = 2;
    localparam int LATCH_CYCLES = 2;

    // Bits needed to hold T = base_ticks << (bcm_bits-1).
    function automatic int window_width(int base_ticks, int bcm_bits);
        return $clog2(base_ticks) + bcm_bits;
    endfunction

    // Full width of T * dim_q so the product never overflows before the shift.
    function automatic int on_ticks_width(int base_ticks, int bcm_bits, int dim_width);
        return $clog2(base_ticks) + bcm_bits + dim_width;
    endfunction

endpackage

// File: rtl/matrix_scan_bcm_if.sv
// Panel-timing bundle between the scan generator and the fetch / pixel_split path.
// The master side is the scan generator; enable and dim_level flow into it.
interface matrix_scan_bcm_if #(
    parameter int COLUMNS   = 64,
    parameter int ROW_BITS  = 4,
    parameter int BCM_BITS  = 6,
    parameter int DIM_WIDTH = 8
);
    localparam int COL_W = $clog2(COLUMNS);

    logic                 enable;
    logic [DIM_WIDTH-1:0] dim_level;
    logic [COL_W-1:0]     column_address;
    logic [ROW_BITS-1:0]  row_address;
    logic [ROW_BITS-1:0]  row_address_active;
    logic                 clk_pixel_load;
    logic                 clk_pixel;
    logic                 row_latch;
    logic                 output_enable;
    logic [BCM_BITS-1:0]  brightness_mask;
    logic                 frame_start;

    modport master (
        input  enable,
        input  dim_level,
        output column_address,
        output row_address,
        output row_address_active,
        output clk_pixel_load,
        output clk_pixel,
        output row_latch,
        output output_enable,
        output brightness_mask,
        output frame_start
    );

    modport slave (
        output enable,
        output dim_level,
        input  column_address,
        input  row_address,
        input  row_address_active,
        input  clk_pixel_load,
        input  clk_pixel,
        input  row_latch,
        input  output_enable,
        input  brightness_mask,
        input  frame_start
    );

endinterface

// File: rtl/matrix_scan_bcm_oe_window_timer.sv
// Times one SHOW window of BASE_TICKS << plane cycles and keeps OE high for
// the dimmed prefix of it; done flags the last cycle of the window.
module oe_window_timer
    import matrix_scan_pkg::*;
#(
    parameter int BCM_BITS   = 6,
    parameter int BASE_TICKS = 16,
    parameter int DIM_WIDTH  = 8,
    parameter int PLANE_W    = 3
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PLANE_W-1:0]   plane_idx,
    input  logic [DIM_WIDTH-1:0] dim_q,
    output logic                 output_enable,
    output logic                 done
);
    localparam int TW = window_width(BASE_TICKS, BCM_BITS);
    localparam int PW = on_ticks_width(BASE_TICKS, BCM_BITS, DIM_WIDTH);

    logic [PW-1:0] window_full;
    logic [PW-1:0] product;
    logic [TW-1:0] window_len;
    logic [TW-1:0] on_ticks;

    logic [TW-1:0] tick_reg, tick_next;
    logic          active_reg, active_next;
    logic          oe_reg, oe_next;

    always_comb begin
        window_full = PW'(BASE_TICKS) << plane_idx;
        product     = window_full * PW'(dim_q);
        on_ticks    = TW'(product >> DIM_WIDTH);
        window_len  = TW'(window_full);
    end

    assign done          = active_reg && (tick_reg == window_len - TW'(1));
    assign output_enable = oe_reg;

    always_comb begin
        active_next = active_reg;
        tick_next   = tick_reg;
        oe_next     = oe_reg;
        if (start) begin
            active_next = 1'b1;
            tick_next   = '0;
            oe_next     = (on_ticks != '0);
        end else if (active_reg) begin
            if (done) begin
                active_next = 1'b0;
                tick_next   = '0;
                oe_next     = 1'b0;
            end else begin
                tick_next = tick_reg + TW'(1);
                // OE already reflects the tick being entered, so it is registered.
                oe_next   = (tick_reg + TW'(1)) < on_ticks;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            active_reg <= 1'b0;
            tick_reg   <= '0;
            oe_reg     <= 1'b0;
        end else begin
            active_reg <= active_next;
            tick_reg   <= tick_next;
            oe_reg     <= oe_next;
        end
    end

endmodule

// File: rtl/matrix_scan_bcm.sv
// HUB75 row/column/latch/OE scan generator with binary-coded modulation and
// global dimming. All panel outputs come straight from registers.
module matrix_scan_bcm
    import matrix_scan_pkg::*;
#(
    parameter int COLUMNS    = 64,
    parameter int ROW_BITS   = 4,
    parameter int BCM_BITS   = 6,
    parameter int PIXEL_DIV  = 1,
    parameter int BASE_TICKS = 16,
    parameter int DIM_WIDTH  = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    matrix_scan_bcm_if.master bus
);
    localparam int COL_W   = $clog2(COLUMNS);
    localparam int PIX_W   = $clog2(2 * PIXEL_DIV);
    localparam int PLANE_W = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;
    localparam int PHASE_W = 2;

    localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(2 * PIXEL_DIV - 1);
    localparam logic [PIX_W-1:0]   PIX_HIGH   = PIX_W'(PIXEL_DIV);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLUMNS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BCM_BITS - 1);
    localparam logic [PHASE_W-1:0] BLANK_LAST = PHASE_W'(BLANK_CYCLES - 1);
    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);

    scan_state_t          state_reg, state_next;
    logic [PIX_W-1:0]     pix_reg, pix_next;
    logic [COL_W-1:0]     col_reg, col_next;
    logic [PHASE_W-1:0]   phase_reg, phase_next;

    logic [ROW_BITS-1:0]  row_reg, row_next;
    logic [ROW_BITS-1:0]  row_active_reg, row_active_next;
    logic [BCM_BITS-1:0]  mask_reg, mask_next, mask_rot;
    logic [PLANE_W-1:0]   plane_reg, plane_next;
    logic [DIM_WIDTH-1:0] dim_q_reg, dim_q_next;
    logic                 load_reg, load_next;
    logic                 clk_pixel_reg, clk_pixel_next;
    logic                 row_latch_reg, row_latch_next;
    logic                 frame_reg, frame_next;

    logic timer_start, timer_done, timer_oe, show_done;

    genvar gi;
    generate
        for (gi = 0; gi < BCM_BITS; gi++) begin : g_mask_rot
            assign mask_rot[gi] = mask_reg[(gi + BCM_BITS - 1) % BCM_BITS];
        end
    endgenerate

    assign timer_start = (state_reg == LATCH) && (phase_reg == LATCH_LAST);
    assign show_done   = (state_reg == SHOW) && timer_done;

    oe_window_timer #(
        .BCM_BITS   (BCM_BITS),
        .BASE_TICKS (BASE_TICKS),
        .DIM_WIDTH  (DIM_WIDTH),
        .PLANE_W    (PLANE_W)
    ) u_oe_timer (
        .clk_in        (clk_in),
        .reset         (reset),
        .start         (timer_start),
        .plane_idx     (plane_reg),
        .dim_q         (dim_q_reg),
        .output_enable (timer_oe),
        .done          (timer_done)
    );

    // State register, also holding every registered output.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg      <= IDLE;
            pix_reg        <= '0;
            col_reg        <= '0;
            phase_reg      <= '0;
            row_reg        <= '0;
            row_active_reg <= '0;
            mask_reg       <= BCM_BITS'(1);
            plane_reg      <= '0;
            dim_q_reg      <= '0;
            load_reg       <= 1'b0;
            clk_pixel_reg  <= 1'b0;
            row_latch_reg  <= 1'b0;
            frame_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pix_reg        <= pix_next;
            col_reg        <= col_next;
            phase_reg      <= phase_next;
            row_reg        <= row_next;
            row_active_reg <= row_active_next;
            mask_reg       <= mask_next;
            plane_reg      <= plane_next;
            dim_q_reg      <= dim_q_next;
            load_reg       <= load_next;
            clk_pixel_reg  <= clk_pixel_next;
            row_latch_reg  <= row_latch_next;
            frame_reg      <= frame_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        pix_next   = pix_reg;
        col_next   = col_reg;
        phase_next = phase_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.enable) begin
                    state_next = SHIFT;
                    pix_next   = '0;
                end
            end
            SHIFT: begin
                if (pix_reg == PIX_LAST) begin
                    pix_next = '0;
                    if (col_reg == COL_LAST) begin
                        col_next   = '0;
                        phase_next = '0;
                        state_next = BLANK;
                    end else begin
                        col_next = col_reg + COL_W'(1);
                    end
                end else begin
                    pix_next = pix_reg + PIX_W'(1);
                end
            end
            BLANK: begin
                if (phase_reg == BLANK_LAST) begin
                    phase_next = '0;
                    state_next = LATCH;
                end else begin
                    phase_next = phase_reg + PHASE_W'(1);
                end
            end
            LATCH: begin
                if (phase_reg == LATCH_LAST) begin
                    phase_next = '0;
                    state_next = SHOW;
                end else begin
                    phase_next = phase_reg + PHASE_W'(1);
                end
            end
            SHOW: begin
                if (timer_done) begin
                    pix_next   = '0;
                    state_next = bus.enable ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        load_next       = (state_next == SHIFT) && (pix_next == '0);
        clk_pixel_next  = (state_next == SHIFT) && (pix_next >= PIX_HIGH);
        row_latch_next  = (state_next == LATCH);
        row_active_next = row_active_reg;
        dim_q_next      = dim_q_reg;
        mask_next       = mask_reg;
        plane_next      = plane_reg;
        row_next        = row_reg;
        frame_next      = 1'b0;

        // Active row only moves on entry to LATCH, when OE is guaranteed low.
        if ((state_reg == BLANK) && (state_next == LATCH))
            row_active_next = row_reg;
        if ((state_reg == LATCH) && (phase_reg == '0))
            dim_q_next = bus.dim_level;

        if (show_done) begin
            mask_next = mask_rot;
            if (plane_reg == PLANE_LAST) begin
                plane_next = '0;
                row_next   = row_reg + ROW_BITS'(1);
                frame_next = (row_reg == '1);
            end else begin
                plane_next = plane_reg + PLANE_W'(1);
            end
        end
    end

    assign bus.column_address     = col_reg;
    assign bus.row_address        = row_reg;
    assign bus.row_address_active = row_active_reg;
    assign bus.clk_pixel_load     = load_reg;
    assign bus.clk_pixel          = clk_pixel_reg;
    assign bus.row_latch          = row_latch_reg;
    assign bus.output_enable      = timer_oe;
    assign bus.brightness_mask    = mask_reg;
    assign bus.frame_start        = frame_reg;

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Self-checking bench for matrix_scan_bcm: a table of hand-derived planes, a few
// multi-cycle corner sequences, then random planes against a plane-level model.
module tb_matrix_scan_bcm;
    localparam int C  = 4;
    localparam int RB = 1;
    localparam int BB = 2;
    localparam int PD = 1;
    localparam int BT = 16;
    localparam int DW = 8;
    localparam int SHIFT_LEN = C * 2 * PD;

    typedef struct {
        int dim;
        int dim_after;
        bit drop;
        int mask;
        int row;
        int on;
        int len;
        int nmask;
        int nrow;
        bit frame;
    } vec_t;

    logic clk_in = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    matrix_scan_bcm_if #(.COLUMNS(C), .ROW_BITS(RB), .BCM_BITS(BB), .DIM_WIDTH(DW)) bus ();

    matrix_scan_bcm #(
        .COLUMNS(C), .ROW_BITS(RB), .BCM_BITS(BB),
        .PIXEL_DIV(PD), .BASE_TICKS(BT), .DIM_WIDTH(DW)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic void check(string name, int actual, int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endfunction

    task automatic run_plane(input int dim, input int dim_after, input bit drop,
                             input int exp_mask, input int exp_row, input int exp_on,
                             input int exp_len, input int exp_nmask, input int exp_nrow,
                             input bit exp_frame);
        int wait_n;
        int k;
        int on_cnt;
        bus.dim_level = DW'(dim);
        bus.enable    = 1'b1;
        wait_n = 0;
        while (!bus.clk_pixel_load && wait_n < 200) begin
            @(negedge clk_in);
            wait_n++;
        end
        check("shift_start_timeout", int'(wait_n < 200), 1);
        for (int i = 0; i < SHIFT_LEN; i++) begin
            if (i > 0) @(negedge clk_in);
            if (drop && i == 2 * PD) bus.enable = 1'b0;
            check("shift_load", int'(bus.clk_pixel_load), int'((i % (2 * PD)) == 0));
            check("shift_clk_pixel", int'(bus.clk_pixel), int'((i % (2 * PD)) >= PD));
            check("shift_column", int'(bus.column_address), i / (2 * PD));
            check("shift_row", int'(bus.row_address), exp_row);
            check("shift_mask", int'(bus.brightness_mask), exp_mask);
            check("shift_oe", int'(bus.output_enable), 0);
            check("shift_latch", int'(bus.row_latch), 0);
            if (i > 0) check("shift_frame", int'(bus.frame_start), 0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            check("blank_column_wrap", int'(bus.column_address), 0);
            check("blank_latch", int'(bus.row_latch), 0);
            check("blank_oe", int'(bus.output_enable), 0);
            check("blank_clk_pixel", int'(bus.clk_pixel), 0);
            check("blank_load", int'(bus.clk_pixel_load), 0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            check("latch_strobe", int'(bus.row_latch), 1);
            check("latch_oe", int'(bus.output_enable), 0);
            if (i == 0) check("latch_row_active", int'(bus.row_address_active), exp_row);
        end
        k = 0;
        on_cnt = 0;
        @(negedge clk_in);
        while (int'(bus.brightness_mask) == exp_mask && k < 4096) begin
            check("show_oe", int'(bus.output_enable), int'(k < exp_on));
            check("show_row_active", int'(bus.row_address_active), exp_row);
            check("show_latch", int'(bus.row_latch), 0);
            check("show_frame", int'(bus.frame_start), 0);
            if (k == 3) bus.dim_level = DW'(dim_after);
            on_cnt += int'(bus.output_enable);
            k++;
            @(negedge clk_in);
        end
        check("show_len", k, exp_len);
        check("show_on_ticks", on_cnt, exp_on);
        check("end_mask", int'(bus.brightness_mask), exp_nmask);
        check("end_row", int'(bus.row_address), exp_nrow);
        check("end_frame_start", int'(bus.frame_start), int'(exp_frame));
        check("end_oe", int'(bus.output_enable), 0);
        if (drop) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk_in);
                check("idle_oe", int'(bus.output_enable), 0);
                check("idle_load", int'(bus.clk_pixel_load), 0);
                check("idle_mask", int'(bus.brightness_mask), exp_nmask);
                check("idle_row", int'(bus.row_address), exp_nrow);
            end
        end
        $display("plane mask=%0d row=%0d dim=%0d drop=%0d show=%0d on=%0d (want %0d/%0d)",
                 exp_mask, exp_row, dim, drop, k, on_cnt, exp_on, exp_len);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   wait_n;
        int   m_plane, m_row, dim, dim_after, len, on, np, nr;
        bit   drop, fr;

        tbl[0] = '{255, 255, 1'b0, 1, 0, 15, 16, 2, 0, 1'b0};
        tbl[1] = '{255, 255, 1'b0, 2, 0, 31, 32, 1, 1, 1'b0};
        tbl[2] = '{128, 128, 1'b0, 1, 1,  8, 16, 2, 1, 1'b0};
        tbl[3] = '{128, 128, 1'b0, 2, 1, 16, 32, 1, 0, 1'b1};
        tbl[4] = '{  0,   0, 1'b0, 1, 0,  0, 16, 2, 0, 1'b0};
        tbl[5] = '{  0,   0, 1'b0, 2, 0,  0, 32, 1, 1, 1'b0};
        tbl[6] = '{200,   0, 1'b1, 1, 1, 12, 16, 2, 1, 1'b0};
        tbl[7] = '{ 64,  64, 1'b0, 2, 1,  8, 32, 1, 0, 1'b1};

        reset = 1'b1;
        bus.enable = 1'b0;
        bus.dim_level = '0;
        repeat (3) @(negedge clk_in);
        check("rst_column", int'(bus.column_address), 0);
        check("rst_row", int'(bus.row_address), 0);
        check("rst_row_active", int'(bus.row_address_active), 0);
        check("rst_load", int'(bus.clk_pixel_load), 0);
        check("rst_clk_pixel", int'(bus.clk_pixel), 0);
        check("rst_latch", int'(bus.row_latch), 0);
        check("rst_oe", int'(bus.output_enable), 0);
        check("rst_frame", int'(bus.frame_start), 0);
        check("rst_mask", int'(bus.brightness_mask), 1);

        reset = 1'b0;
        bus.enable = 1'b1;
        bus.dim_level = 8'd255;
        @(negedge clk_in);
        check("first_load_latency", int'(bus.clk_pixel_load), 1);

        for (int i = 0; i < 8; i++)
            run_plane(tbl[i].dim, tbl[i].dim_after, tbl[i].drop, tbl[i].mask, tbl[i].row,
                      tbl[i].on, tbl[i].len, tbl[i].nmask, tbl[i].nrow, tbl[i].frame);

        // Reset in the middle of a plane-1 SHOW window.
        wait_n = 0;
        while (!(int'(bus.brightness_mask) == 2 && bus.row_latch) && wait_n < 500) begin
            @(negedge clk_in);
            wait_n++;
        end
        while (bus.row_latch && wait_n < 500) begin
            @(negedge clk_in);
            wait_n++;
        end
        check("reset_seq_timeout", int'(wait_n < 500), 1);
        repeat (5) @(negedge clk_in);
        check("pre_reset_oe", int'(bus.output_enable), 1);
        reset = 1'b1;
        @(negedge clk_in);
        check("midshow_rst_oe", int'(bus.output_enable), 0);
        check("midshow_rst_mask", int'(bus.brightness_mask), 1);
        check("midshow_rst_row", int'(bus.row_address), 0);
        check("midshow_rst_load", int'(bus.clk_pixel_load), 0);
        check("midshow_rst_latch", int'(bus.row_latch), 0);
        reset = 1'b0;
        @(negedge clk_in);
        check("restart_load", int'(bus.clk_pixel_load), 1);
        check("restart_column", int'(bus.column_address), 0);
        $display("reset mid-SHOW: oe=0 mask=1 row=0, restart load=%0d", bus.clk_pixel_load);

        m_plane = 0;
        m_row = 0;
        for (int n = 0; n < 12; n++) begin
            dim = int'($urandom_range(0, 255));
            dim_after = int'($urandom_range(0, 255));
            drop = ($urandom_range(0, 3) == 0);
            len = BT << m_plane;
            on = (len * dim) >> DW;
            np = (m_plane + 1) % BB;
            nr = m_row;
            fr = 1'b0;
            if (np == 0) begin
                nr = (m_row + 1) % (1 << RB);
                fr = (nr == 0);
            end
            run_plane(dim, dim_after, drop, 1 << m_plane, m_row, on, len, 1 << np, nr, fr);
            m_plane = np;
            m_row = nr;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
